scan_decoder: RTL
=================

// Module: scan_decoder
// PURPOSE
//  Parametrised time-multiplexed decoder: steps a registered select index through
//  2**N channels at a programmable dwell rate and drives a one-hot output.
//  Channels can be skipped via a mask.
//  Drives 7-segment anode/digit strobes and row scans in the display datapath.
//  Replaces a static combinational decoder plus an external counter.
// PARAMETERS
//  N          2   select width; channel count = 2**N
//  DIV_W      16  width of dwell-period input
//  ACTIVE_LOW 1   1: selected output bit driven 0, others 1; 0: one-hot high
//  BLANK_CYC  4   blanking cycles between channels (only with SCAN_BLANK_EN), >=1
// PORTS
//  clk      in   1        system clock, rising edge
//  rst      in   1        asynchronous, active-high reset
//  en       in   1        scan enable
//  div      in   DIV_W    dwell period; channel held div+1 cycles
//  mask     in   2**N     channel enable; bit i=1 -> channel i is scanned
//  sel      out  N        current channel index (registered)
//  onehot   out  2**N     decoded strobe (registered, polarity per ACTIVE_LOW)
//  wrap     out  1        1-cycle pulse when scan wraps to a lower/equal index
// BEHAVIOUR
//  - "Inactive" output: all ones if ACTIVE_LOW=1, else all zeros.
//  - Reset (async, any time, incl. mid-dwell): state=IDLE, prescaler=0, sel=0,
//    onehot=inactive, wrap=0. Outputs change on reset assertion, no clock needed.
//  - FSM states: IDLE, SCAN, BLANK (BLANK only with SCAN_BLANK_EN).
//  - IDLE: onehot inactive, prescaler=0, sel holds.
//    IDLE->SCAN on the edge where en && |mask.
//    On that edge: sel <= lowest set bit of mask; onehot <= decode(sel).
//  - SCAN: prescaler increments each cycle. Terminal when prescaler >= div.
//    Use >=, not ==, so a div lowered mid-dwell cannot overrun.
//    div=0 -> advance every cycle.
//  - On terminal: prescaler <= 0; next = first set mask bit strictly after sel,
//    circular. A single enabled channel re-selects itself.
//    wrap <= 1 for one cycle iff next <= sel.
//  - mask is sampled at each advance. Clearing the bit of the current channel
//    takes effect at its next advance, not mid-dwell.
//  - en=0 or mask==0 in SCAN/BLANK: next edge -> IDLE, onehot inactive,
//    prescaler=0, wrap=0. sel holds.
//  - Simultaneous terminal and en falling: IDLE wins, no wrap pulse.
//  - sel and onehot always agree on the same edge; latency is 1 clk from a
//    decision to the outputs. No combinational input->output paths.
// CONFIGURATION
//  SCAN_BLANK_EN defined:
//    On terminal go SCAN->BLANK. onehot=inactive for BLANK_CYC cycles (anti-ghosting).
//    sel and wrap update on BLANK entry.
//    On BLANK exit go to SCAN with onehot=decode(sel) and prescaler=0.
//    Period per channel = div+1+BLANK_CYC.
//  SCAN_BLANK_EN undefined:
//    No BLANK state; SCAN->SCAN directly. onehot never goes inactive between channels.
// TESTING  (N=2, ACTIVE_LOW=0 unless stated)
//  1 rst=1 for 3 clk, en=0 -> sel=0, onehot=4'b0000, wrap=0; stays so after release.
//  2 en=1, mask=4'b1111, div=2 -> onehot 0001,0010,0100,1000 for 3 clk each,
//    then 0001 again with wrap=1 for exactly 1 clk.
//  3 mask=4'b0101, div=0 -> onehot 0001,0100,0001,... each 1 clk;
//    wrap pulses on every entry to 0001.
//  4 mid-scan, mask->4'b0000 -> next edge onehot=0000, state IDLE;
//    mask->4'b1000 -> onehot=1000, sel=3.
//  5 rst pulse mid-dwell (prescaler=1, sel=2) -> immediate sel=0, onehot=0000;
//    after release with en=1, mask=4'b1111, scan restarts at 0001.
//  6 ACTIVE_LOW=1, SCAN_BLANK_EN, BLANK_CYC=2, div=1, mask=4'b0011 -> onehot
//    1110 x2, 1111 x2, 1101 x2, 1111 x2, 1110 ...

Source files
------------

// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - time-multiplexed one-hot scan decoder with channel mask and dwell prescaler
// Optional SCAN_BLANK_EN inserts BLANK_CYC inactive cycles between channels.
module scan_decoder #(
  parameter int N          = 2,
  parameter int DIV_W      = 16,
  parameter int ACTIVE_LOW = 1,
  parameter int BLANK_CYC  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic [(1<<N)-1:0] mask,
  output logic [N-1:0]     sel,
  output logic [(1<<N)-1:0] onehot,
  output logic             wrap
);

  localparam int C  = 1 << N;
  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [C-1:0] INACT = (ACTIVE_LOW != 0) ? {C{1'b1}} : {C{1'b0}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_BLANK = 2'd2} state_t;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_presc, w_presc_nxt;
  logic [BW-1:0]    r_bcnt, w_bcnt_nxt;
  logic [N-1:0]     r_sel, w_sel_nxt;
  logic [C-1:0]     r_onehot, w_onehot_nxt;
  logic             r_wrap, w_wrap_nxt;
  logic             w_go, w_term, w_bdone;
  logic [N-1:0]     w_next_ch, w_first_ch;

  function automatic logic [C-1:0] f_decode(input logic [N-1:0] s);
    logic [C-1:0] v;
    v = {{(C-1){1'b0}}, 1'b1} << s;
    return (ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  // Circular search starting just after s; k == C lands back on s itself.
  function automatic logic [N-1:0] f_next(input logic [N-1:0] s, input logic [C-1:0] m);
    logic [N-1:0] r;
    logic [N-1:0] c;
    logic         hit;
    r   = s;
    hit = 1'b0;
    for (int k = 1; k <= C; k++) begin
      c = s + N'(k);
      if (!hit && m[c]) begin
        r   = c;
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] f_first(input logic [C-1:0] m);
    logic [N-1:0] r;
    r = '0;
    for (int i = C - 1; i >= 0; i--) begin
      if (m[i]) r = N'(i);
    end
    return r;
  endfunction

  assign w_go       = en && (|mask);
  assign w_term     = (r_presc >= div);
  assign w_bdone    = (r_bcnt == BW'(BLANK_CYC - 1));
  assign w_next_ch  = f_next(r_sel, mask);
  assign w_first_ch = f_first(mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_bcnt   <= '0;
      r_sel    <= '0;
      r_onehot <= INACT;
      r_wrap   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_presc  <= w_presc_nxt;
      r_bcnt   <= w_bcnt_nxt;
      r_sel    <= w_sel_nxt;
      r_onehot <= w_onehot_nxt;
      r_wrap   <= w_wrap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_state_nxt = S_SCAN;
      S_SCAN: begin
        if (!w_go) w_state_nxt = S_IDLE;
`ifdef SCAN_BLANK_EN
        else if (w_term) w_state_nxt = S_BLANK;
`else
        else if (w_term) w_state_nxt = S_SCAN;
`endif
      end
      S_BLANK: begin
        if (!w_go) w_state_nxt = S_IDLE;
        else if (w_bdone) w_state_nxt = S_SCAN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Leaving to IDLE falls through to the defaults: inactive strobe, no wrap, sel held.
  always_comb begin
    w_sel_nxt    = r_sel;
    w_onehot_nxt = INACT;
    w_wrap_nxt   = 1'b0;
    w_presc_nxt  = '0;
    w_bcnt_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_sel_nxt    = w_first_ch;
          w_onehot_nxt = f_decode(w_first_ch);
        end
      end
      S_SCAN: begin
        if (w_go) begin
          if (w_term) begin
            w_sel_nxt  = w_next_ch;
            w_wrap_nxt = (w_next_ch <= r_sel);
`ifdef SCAN_BLANK_EN
            w_onehot_nxt = INACT;
`else
            w_onehot_nxt = f_decode(w_next_ch);
`endif
          end else begin
            w_presc_nxt  = r_presc + 1'b1;
            w_onehot_nxt = f_decode(r_sel);
          end
        end
      end
      S_BLANK: begin
        if (w_go) begin
          if (w_bdone) w_onehot_nxt = f_decode(r_sel);
          else         w_bcnt_nxt   = r_bcnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign sel    = r_sel;
  assign onehot = r_onehot;
  assign wrap   = r_wrap;

endmodule
